// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem fetch, output register + skid buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets are rejected and flagged on misalign_err.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_src,
   input  logic [31:0] pc_addr,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign_err
);

   // imem handshake: a request is accepted on an edge where imem_req and imem_ready are both high;
   // exactly one imem_rvalid follows each accepted request, at least one cycle later.
   typedef enum logic {S_REQ, S_WAIT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic        drop;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic        accept;
   logic        redirect;
   logic        deliver;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redirect = pc_src & (pc_addr[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_err <= 1'b0;
      else     misalign_err <= pc_src & (pc_addr[1:0] != 2'b00);
   end
`else
   assign redirect     = pc_src;
   assign misalign_err = 1'b0;
`endif

   assign imem_addr = pc;
   assign accept    = imem_req & imem_ready;
   assign deliver   = (state == S_WAIT) & imem_rvalid & ~drop & ~redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      case (state)
         S_REQ: begin
            // A full skid means nowhere to put another response, so stop fetching.
            imem_req = ~skid_valid & ~rst;
            if (imem_req && imem_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         req_pc     <= RESET_PC;
         drop       <= 1'b0;
         if_valid   <= 1'b0;
         if_pc      <= 32'h0;
         if_instr   <= NOP_INSTR;
         skid_valid <= 1'b0;
         skid_pc    <= 32'h0;
         skid_instr <= NOP_INSTR;
      end else begin
         if (accept) req_pc <= pc;
         if (redirect) begin
            pc         <= pc_addr & ~32'h3;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
            // The in-flight (or just-accepted) fetch is wrong-path; a coincident rvalid is simply discarded.
            if (accept || (state == S_WAIT && !imem_rvalid)) drop <= 1'b1;
            else if (state == S_WAIT && imem_rvalid)         drop <= 1'b0;
         end else begin
            if (accept) pc <= pc + 32'd4;
            if (state == S_WAIT && imem_rvalid) drop <= 1'b0;
            if (!stall && skid_valid) begin
               if_valid   <= 1'b1;
               if_pc      <= skid_pc;
               if_instr   <= skid_instr;
               skid_valid <= 1'b0;
            end else if (deliver) begin
               if (!if_valid || !stall) begin
                  if_valid <= 1'b1;
                  if_pc    <= req_pc;
                  if_instr <= imem_rdata;
               end else begin
                  skid_valid <= 1'b1;
                  skid_pc    <= req_pc;
                  skid_instr <= imem_rdata;
               end
            end else if (!stall) begin
               if_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable imem model, accept/consume logs, hand-derived expectations.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] pc_addr = 32'h0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_err;

   fetch_unit dut (
      .clk(clk), .rst(rst), .pc_src(pc_src), .pc_addr(pc_addr), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ 32'hA5A5_0000) | 32'h3;
   endfunction

   // Memory model and monitor: sample 1 unit before each rising edge, respond 1 unit after it.
   logic [31:0] acc_q[$];
   logic [31:0] cons_pc_q[$];
   logic [31:0] cons_in_q[$];
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          cnt = 0;
   int          lat = 1;
   int          inject_req = 0, inject_seen = 0;
   int          flush_req = 0, flush_seen = 0;

   always begin
      @(negedge clk);
      #4;
      if (imem_req && imem_ready) begin
         acc_q.push_back(imem_addr);
         pend      = 1'b1;
         pend_addr = imem_addr;
         cnt       = lat;
      end
      if (if_valid && !stall && !pc_src && !rst) begin
         cons_pc_q.push_back(if_pc);
         cons_in_q.push_back(if_instr);
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (inject_req != inject_seen) begin
         inject_seen = inject_req;
         pend        = 1'b0;
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end else if (flush_req != flush_seen) begin
         flush_seen = flush_req;
         pend       = 1'b0;
      end else if (pend) begin
         if (cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
         end else begin
            cnt--;
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int lat_v);
      @(negedge clk);
      rst = 1'b1;
      stall = 1'b0;
      pc_src = 1'b0;
      lat = lat_v;
      flush_req++;
      run(2);
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      pc_src  = 1'b1;
      pc_addr = target;
      run(1);
      pc_src  = 1'b0;
   endtask

   task automatic check_stream(input int from, input logic [31:0] first, input int min_n);
      logic [31:0] e;
      e = first;
      check("stream_len_ok", (cons_pc_q.size() - from >= min_n) ? 32'd1 : 32'd0, 32'd1);
      for (int i = from; i < cons_pc_q.size(); i++) begin
         check("stream_pc", cons_pc_q[i], e);
         check("stream_instr", cons_in_q[i], mem_word(e));
         e = e + 32'd4;
      end
   endtask

   task automatic wait_acc(input logic [31:0] addr);
      int  start;
      bit  ok;
      start = acc_q.size();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (acc_q.size() > start && acc_q[$] == addr) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_acc_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic check_acc(input string tag, input int idx, input logic [31:0] exp);
      if (idx < acc_q.size()) check(tag, acc_q[idx], exp);
      else                    check(tag, 32'hFFFF_FFFF, exp ^ 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int          i0, c0, a0;
      logic [31:0] p;
      bit          ok;

      // Reset values
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, NOP);
      check("rst_misalign", {31'd0, misalign_err}, 32'd0);

      // Streaming, 1-cycle memory: one instruction every two cycles
      do_reset(1);
      i0 = cons_pc_q.size();
      a0 = acc_q.size();
      run(12);
      check("stream_count", cons_pc_q.size() - i0, 32'd5);
      for (int k = 0; k < 4; k++) check_acc("stream_addr", a0 + k, 32'(4 * k));

      // Stall with output and skid both full
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (if_valid) begin ok = 1'b1; break; end
      end
      check("wait_valid_timeout", {31'd0, ok}, 32'd1);
      p = 32'(4 * (cons_pc_q.size() - i0));
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         run(1);
         check("stall_valid", {31'd0, if_valid}, 32'd1);
         check("stall_pc", if_pc, p);
         check("stall_instr", if_instr, mem_word(p));
         if (k >= 1) check("stall_no_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      run(1);
      check("skid_out_valid", {31'd0, if_valid}, 32'd1);
      check("skid_out_pc", if_pc, p + 32'd4);
      run(6);
      check_stream(i0, 32'h0, 8);

      // Redirect while waiting on address 8 (3-cycle memory)
      do_reset(3);
      wait_acc(32'h8);
      c0 = cons_pc_q.size();
      a0 = acc_q.size();
      redirect(32'h100);
      check("redir_wait_valid", {31'd0, if_valid}, 32'd0);
      check("redir_wait_instr", if_instr, NOP);
      run(20);
      check_acc("redir_wait_addr", a0, 32'h100);
      check_stream(c0, 32'h100, 2);

      // Redirect on the same edge as the accept of address 12
      do_reset(1);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'hC) begin ok = 1'b1; break; end
      end
      check("wait_addr12_timeout", {31'd0, ok}, 32'd1);
      c0 = cons_pc_q.size();
      a0 = acc_q.size();
      redirect(32'h200);
      run(10);
      check_acc("redir_acc_12", a0, 32'hC);
      check_acc("redir_acc_tgt", a0 + 1, 32'h200);
      check_stream(c0, 32'h200, 2);

      // Redirect to the top word: PC wraps to 0
      do_reset(1);
      c0 = cons_pc_q.size();
      a0 = acc_q.size();
      redirect(32'hFFFF_FFFC);
      run(10);
      check_acc("wrap_acc0", a0, 32'h0);
      check_acc("wrap_acc1", a0 + 1, 32'hFFFF_FFFC);
      check_acc("wrap_acc2", a0 + 2, 32'h0);
      check_stream(c0, 32'hFFFF_FFFC, 2);

      // Misaligned redirect target
      do_reset(1);
      c0 = cons_pc_q.size();
      a0 = acc_q.size();
      redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("misalign_pulse", {31'd0, misalign_err}, 32'd1);
      run(1);
      check("misalign_clear", {31'd0, misalign_err}, 32'd0);
      run(8);
      check_acc("misalign_acc1", a0 + 1, 32'h4);
      check_stream(c0, 32'h0, 2);
`else
      check("misalign_tied", {31'd0, misalign_err}, 32'd0);
      run(9);
      check_acc("misalign_acc1", a0 + 1, 32'h100);
      check_stream(c0, 32'h100, 2);
`endif

      // Reset mid-WAIT, then a stale rvalid while the FSM is back in REQ
      do_reset(3);
      wait_acc(32'hC);
      rst = 1'b1;
      #1;
      check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
      check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
      check("midrst_if_pc", if_pc, 32'h0);
      check("midrst_if_instr", if_instr, NOP);
      inject_req++;
      @(negedge clk);
      c0 = cons_pc_q.size();
      a0 = acc_q.size();
      rst = 1'b0;
      run(15);
      check_acc("midrst_first_addr", a0, 32'h0);
      check_acc("midrst_second_addr", a0 + 1, 32'h4);
      check_stream(c0, 32'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
